// File: rtl/mtx_elem_accum.sv
// mtx_elem_accum: sums N_ACC 4x4 product matrices elementwise, one row of 4 adds per cycle
module mtx_elem_accum #(
   parameter int W     = 8,
   parameter int N_ACC = 4,
   parameter int ACC_W = 20
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [16*2*W-1:0]     i_mtx_m,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [16*ACC_W-1:0]   o_mtx_acc,
   output logic [7:0]            o_mtx_cnt
);
   localparam int EW = 2*W;
   localparam logic [7:0] LAST = 8'(N_ACC-1);
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;
   state_t              r_state, w_next;
   logic                r_ready;
   logic [1:0]          r_row;
   logic [7:0]          r_cnt;
   logic [16*EW-1:0]    r_hold;
   logic [16*ACC_W-1:0] r_acc;
   logic [4*ACC_W-1:0]  w_sum;
   logic                w_take;
   // r_ready is only ever high while in S_IDLE, so it alone qualifies a transfer
   assign w_take    = i_valid & r_ready;
   assign o_ready   = r_ready;
   assign o_valid   = (r_state == S_OUT);
   assign o_mtx_acc = r_acc;
   assign o_mtx_cnt = r_cnt;
   // Four column adders for the current row; the first matrix of a batch overwrites
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [3:0] w_idx;
      assign w_idx = {r_row, 2'(c)};
      assign w_sum[c*ACC_W +: ACC_W] = (r_cnt == 8'd0 ? '0 : r_acc[w_idx*ACC_W +: ACC_W])
                                       + ACC_W'(r_hold[w_idx*EW +: EW]);
   end
   // State register
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end
   // Next-state: accept -> four row cycles -> back to idle, or to output after the last matrix
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_take ? S_ACC : S_IDLE;
         S_ACC:   w_next = (r_row != 2'd3) ? S_ACC : (r_cnt == LAST) ? S_OUT : S_IDLE;
         S_OUT:   w_next = i_ready ? S_IDLE : S_OUT;
         default: w_next = S_IDLE;
      endcase
   end
   // Datapath: hold capture, row/batch counters, registered ready and the accumulator
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ready <= 1'b0;
         r_row   <= 2'd0;
         r_cnt   <= 8'd0;
         r_hold  <= '0;
         r_acc   <= '0;
      end else begin
         r_ready <= (w_next == S_IDLE);
         if (w_take) begin
            r_hold <= i_mtx_m;
            r_row  <= 2'd0;
         end
         if (r_state == S_ACC) begin
            r_row <= r_row + 2'd1;
            for (int c = 0; c < 4; c++)
               r_acc[(4*int'(r_row)+c)*ACC_W +: ACC_W] <= w_sum[c*ACC_W +: ACC_W];
            if (r_row == 2'd3) r_cnt <= (r_cnt == LAST) ? 8'd0 : r_cnt + 8'd1;
         end
      end
   end
endmodule
